// File: rtl/wb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2m
//
// Two-master, one-slave Wishbone arbiter. Master 0 is the data-side bus
// interface, master 1 the instruction-side one. The grant is registered and
// held for the whole bus cycle (cyc high). When both masters keep requesting,
// the grant alternates between them, so neither master starves.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a stall counter that
// force-terminates a cycle the slave never acks. It answers the master with
// ack=1 and data=0, and it pulses arb_timeout_o for one cycle. Without the
// macro, no counter exists and arb_timeout_o is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  stalled cycles before a forced termination (1..1023)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   m0_* / m1_*    master-side Wishbone: addr/data/we/sel/stb/cyc in,
//                  data/ack out (only the granted master sees ack/data)
//   s_*            slave-side Wishbone: addr/data/we/sel/stb/cyc out,
//                  data/ack in
//   arb_timeout_o  one-cycle pulse when a cycle is force-terminated
//   dbg_state      current arbiter state (0 IDLE, 1 GNT0, 2 GNT1)
//
// Handshake: a slave transfer completes in a cycle where s_cyc_o, s_stb_o
// and s_ack_i are all high. The ack is forwarded combinationally to the
// granted master only, and only while its strobe is forwarded.
// ---------------------------------------------------------------------------
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic        arb_timeout_o,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   timeout;
    logic   ack_int;
    logic   [31:0] rdata_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Master 0 has priority only from IDLE. On release, the other master is
    // tried first, and that gives the alternation under contention.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i)      state_nxt = GNT0;
                else if (m1_cyc_i) state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side mux. cyc follows the granted master directly, so an
    // abandoned cycle (cyc dropped before ack) disappears from the slave bus
    // in the same cycle.
    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        case (state)
            GNT0: begin
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_cyc_i & m0_stb_i;
            end
            GNT1: begin
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_cyc_i & m1_stb_i;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [9:0] stall_cnt;

    // The counter counts strobed cycles that have no ack. It restarts on a
    // new grant, on a real ack, and after a forced termination.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state_nxt != state) || s_ack_i || timeout) begin
            stall_cnt <= '0;
        end else if ((state != IDLE) && s_stb_o) begin
            stall_cnt <= stall_cnt + 10'd1;
        end
    end

    assign timeout = (state != IDLE) && s_stb_o &&
                     (stall_cnt == 10'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // A forced termination acks with zero data, even if the slave acks in
    // the same cycle.
    always_comb begin
        ack_int   = (s_ack_i & s_stb_o) | timeout;
        rdata_int = (ack_int && !timeout) ? s_data_i : 32'h0;
        m0_ack_o  = 1'b0;
        m0_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_data_o = '0;
        case (state)
            GNT0: begin
                m0_ack_o  = ack_int;
                m0_data_o = rdata_int;
            end
            GNT1: begin
                m1_ack_o  = ack_int;
                m1_data_o = rdata_int;
            end
            default: ;
        endcase
    end

    assign arb_timeout_o = timeout;
    assign dbg_state     = state;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_2m
//
// Bench for wb_arbiter_2m. The DUT is built with TIMEOUT_CYCLES = 4. A
// behavioural model tracks which master owns the bus, as an integer (-1 for
// none), plus a stall count. At every falling edge it derives the expected
// outputs, and these are compared with the DUT outputs. Directed scenarios
// come first, each with literal expectations. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_2m;
    localparam int TMO = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_we    [2];
    logic [3:0]  m_sel   [2];
    logic        m_stb   [2];
    logic        m_cyc   [2];
    logic [31:0] s_data_i;
    logic        s_ack_i;

    logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
    logic        m0_ack_o, m1_ack_o, s_we_o, s_stb_o, s_cyc_o, arb_timeout_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  dbg_state;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m_addr[0]), .m0_data_i(m_wdata[0]), .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m_addr[1]), .m1_data_i(m_wdata[1]), .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .arb_timeout_o(arb_timeout_o), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int owner = -1;   // master holding the bus, -1 when none
    int stall = 0;    // strobed cycles without ack under the current owner

    function automatic bit owner_stb();
        return (owner >= 0) && m_cyc[owner] && m_stb[owner];
    endfunction

    function automatic bit tmo_hit();
`ifdef WB_ARB_TIMEOUT_EN
        return owner_stb() && (stall == TMO);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner = -1;
            stall = 0;
        end else begin
            int nxt;
            bit hit;
            hit = tmo_hit();
            if (owner >= 0 && m_cyc[owner])       nxt = owner;
            else if (owner == -1)                 nxt = m_cyc[0] ? 0 : (m_cyc[1] ? 1 : -1);
            else                                  nxt = m_cyc[1-owner] ? 1 - owner : -1;
            if (nxt != owner || s_ack_i || hit)   stall = 0;
            else if (owner_stb())                 stall++;
            owner = nxt;
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] e_addr, e_wdata, e_rdata;
            logic        e_we, e_stb, e_cyc, e_ack, e_to;
            logic [3:0]  e_sel;
            e_addr = 0; e_wdata = 0; e_we = 0; e_sel = 0; e_stb = 0; e_cyc = 0;
            if (owner >= 0) begin
                e_addr  = m_addr[owner];
                e_wdata = m_wdata[owner];
                e_we    = m_we[owner];
                e_sel   = m_sel[owner];
                e_cyc   = m_cyc[owner];
                e_stb   = owner_stb();
            end
            e_to    = tmo_hit();
            e_ack   = (s_ack_i && e_stb) || e_to;
            e_rdata = (e_ack && !e_to) ? s_data_i : 32'h0;
            chk("m_s_addr",  s_addr_o,  e_addr);
            chk("m_s_wdata", s_data_o,  e_wdata);
            chk("m_s_we",    s_we_o,    e_we);
            chk("m_s_sel",   s_sel_o,   e_sel);
            chk("m_s_stb",   s_stb_o,   e_stb);
            chk("m_s_cyc",   s_cyc_o,   e_cyc);
            chk("m_m0_ack",  m0_ack_o,  (owner == 0) ? e_ack : 1'b0);
            chk("m_m0_data", m0_data_o, (owner == 0) ? e_rdata : 32'h0);
            chk("m_m1_ack",  m1_ack_o,  (owner == 1) ? e_ack : 1'b0);
            chk("m_m1_data", m1_data_o, (owner == 1) ? e_rdata : 32'h0);
            chk("m_timeout", arb_timeout_o, e_to);
            chk("m_state",   dbg_state, 32'(owner + 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic req(input int g, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic [3:0] sel);
        m_addr[g]  = addr;
        m_wdata[g] = wdata;
        m_we[g]    = we;
        m_sel[g]   = sel;
        m_cyc[g]   = 1'b1;
        m_stb[g]   = 1'b1;
    endtask

    task automatic drop(input int g);
        m_cyc[g] = 1'b0;
        m_stb[g] = 1'b0;
    endtask

    task automatic rand_cycle();
        rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        for (int g = 0; g < 2; g++) begin
            if (m_cyc[g]) begin
                if ($urandom_range(0, 4) == 0) m_cyc[g] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                m_cyc[g] = 1'b1;
            end
            m_stb[g]   = m_cyc[g] && ($urandom_range(0, 3) != 0);
            m_addr[g]  = $urandom;
            m_wdata[g] = $urandom;
            m_we[g]    = $urandom_range(0, 1) == 1;
            m_sel[g]   = 4'($urandom_range(0, 15));
        end
        s_ack_i  = $urandom_range(0, 2) == 0;
        s_data_i = $urandom;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int g = 0; g < 2; g++) begin
            m_addr[g] = 0; m_wdata[g] = 0; m_we[g] = 0; m_sel[g] = 0;
        end
        s_data_i = 0;
        s_ack_i  = 0;
        rst      = 1'b0;
        req(0, 32'hA000_0000, 32'h0, 1'b0, 4'hF);
        req(1, 32'hB000_0000, 32'h0, 1'b0, 4'hF);

        // Reset held with both masters requesting.
        at_neg();
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_m0_ack", m0_ack_o, 1'b0);
        chk("rst_m1_ack", m1_ack_o, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        tick(); rst = 1'b1;
        at_neg(); chk("rel_pending", dbg_state, 2'd0);
        tick(); at_neg();
        chk("rel_gnt0", dbg_state, 2'd1);
        chk("rel_addr", s_addr_o, 32'hA000_0000);
        tick(); drop(0); drop(1);
        tick(); at_neg(); chk("rel_idle", dbg_state, 2'd0);

        // Single master 1 read, slave acks two cycles after the grant.
        tick(); req(1, 32'h0000_0100, 32'h0, 1'b0, 4'hF);
        at_neg(); chk("m1_wait", dbg_state, 2'd0);
        tick(); at_neg();
        chk("m1_addr", s_addr_o, 32'h0000_0100);
        chk("m1_noack0", m1_ack_o, 1'b0);
        tick(); at_neg(); chk("m1_noack1", m1_ack_o, 1'b0);
        tick(); s_ack_i = 1'b1; s_data_i = 32'hCAFE_F00D;
        at_neg();
        chk("m1_ack", m1_ack_o, 1'b1);
        chk("m1_data", m1_data_o, 32'hCAFE_F00D);
        chk("m1_m0ack", m0_ack_o, 1'b0);
        tick(); s_ack_i = 1'b0; drop(1);
        tick(); at_neg(); chk("m1_idle", dbg_state, 2'd0);

        // Simultaneous request from IDLE: master 0 first, then direct handoff.
        tick();
        req(0, 32'h0000_0200, 32'h1234_5678, 1'b1, 4'b0011);
        req(1, 32'h0000_0300, 32'h0, 1'b0, 4'hF);
        tick(); at_neg();
        chk("sim_state", dbg_state, 2'd1);
        chk("sim_sel", s_sel_o, 4'b0011);
        chk("sim_wdata", s_data_o, 32'h1234_5678);
        chk("sim_we", s_we_o, 1'b1);
        tick(); s_ack_i = 1'b1;
        at_neg(); chk("sim_m0ack", m0_ack_o, 1'b1); chk("sim_m1ack", m1_ack_o, 1'b0);
        tick(); s_ack_i = 1'b0; drop(0);
        at_neg(); chk("sim_dropcyc", s_cyc_o, 1'b0);
        tick(); at_neg();
        chk("sim_gnt1", dbg_state, 2'd2);
        chk("sim_addr1", s_addr_o, 32'h0000_0300);
        tick(); s_ack_i = 1'b1;
        at_neg(); chk("sim_m1ack2", m1_ack_o, 1'b1);
        tick(); s_ack_i = 1'b0; drop(1);
        tick();

        // Flush: master 0 abandons, and the late slave ack is not forwarded.
        req(0, 32'h0000_0400, 32'h0, 1'b0, 4'hF);
        tick(); at_neg(); chk("fl_gnt", dbg_state, 2'd1);
        tick(); drop(0);
        at_neg(); chk("fl_cyc", s_cyc_o, 1'b0); chk("fl_stb", s_stb_o, 1'b0);
        tick(); s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
        at_neg(); chk("fl_ack", m0_ack_o, 1'b0); chk("fl_data", m0_data_o, 32'h0);
        tick(); s_ack_i = 1'b0;

        // Hold: master 1 keeps the grant while master 0 waits.
        req(1, 32'h0000_0500, 32'h0, 1'b0, 4'hF);
        tick(); at_neg(); chk("hd_gnt1", dbg_state, 2'd2);
        tick(); req(0, 32'h0000_0600, 32'h0, 1'b0, 4'hF);
        at_neg(); chk("hd_addr_a", s_addr_o, 32'h0000_0500);
        tick(); at_neg(); chk("hd_addr_b", s_addr_o, 32'h0000_0500);
        tick(); s_ack_i = 1'b1;
        at_neg(); chk("hd_m1ack", m1_ack_o, 1'b1); chk("hd_m0ack", m0_ack_o, 1'b0);
        tick(); s_ack_i = 1'b0; drop(1);
        tick(); at_neg();
        chk("hd_gnt0", dbg_state, 2'd1);
        chk("hd_addr0", s_addr_o, 32'h0000_0600);
        tick(); drop(0);
        tick();

        // Dead slave: a forced ack on every 5th stalled cycle when enabled, never otherwise.
        req(0, 32'h0000_0700, 32'h0, 1'b0, 4'hF);
        tick();
        for (int i = 1; i <= 10; i++) begin
            bit exp_to;
`ifdef WB_ARB_TIMEOUT_EN
            exp_to = (i % (TMO + 1)) == 0;
`else
            exp_to = 1'b0;
`endif
            at_neg();
            chk("to_ack", m0_ack_o, exp_to);
            chk("to_pulse", arb_timeout_o, exp_to);
            chk("to_data", m0_data_o, 32'h0);
            tick();
        end
        drop(0);
        tick();

        // Reset mid-cycle drops the slave bus asynchronously.
        req(0, 32'h0000_0800, 32'h0, 1'b0, 4'hF);
        tick(); s_ack_i = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("mr_cyc", s_cyc_o, 1'b0);
        chk("mr_stb", s_stb_o, 1'b0);
        chk("mr_ack", m0_ack_o, 1'b0);
        tick(); rst = 1'b1; s_ack_i = 1'b0; drop(0);
        tick();

        // Randomized phase, checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rand_cycle();
        end
        tick(); rst = 1'b1;
        at_neg();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter placed directly downstream of the CPU's two Wishbone bus interface units.
- Master 0 is the data-side bus interface; master 1 is the instruction-side bus interface.
- It multiplexes both masters onto the single shared slave bus (memory/peripheral interconnect) and routes ack/read data back to the granted master only.
- Grant is registered and held for the whole bus cycle (cyc high), with alternation when both masters contend.

Parameters:
- TIMEOUT_CYCLES, 255, stall cycles without slave ack before a forced termination (used only with the optional feature; range 1..1023).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- m0_addr_i  input  32  master 0 address
- m0_data_i  input  32  master 0 write data
- m0_we_i  input  1  master 0 write enable
- m0_sel_i  input  4  master 0 byte selects
- m0_stb_i  input  1  master 0 strobe
- m0_cyc_i  input  1  master 0 cycle
- m0_data_o  output  32  read data to master 0
- m0_ack_o  output  1  ack to master 0
- m1_addr_i, m1_data_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i  input  32/32/1/4/1/1  master 1 equivalents
- m1_data_o  output  32  read data to master 1
- m1_ack_o  output  1  ack to master 1
- s_addr_o  output  32  slave address
- s_data_o  output  32  slave write data
- s_we_o  output  1  slave write enable
- s_sel_o  output  4  slave byte selects
- s_stb_o  output  1  slave strobe
- s_cyc_o  output  1  slave cycle
- s_data_i  input  32  slave read data
- s_ack_i  input  1  slave ack
- arb_timeout_o  output  1  one-cycle pulse when a cycle is force-terminated

Behaviour:
- States: IDLE, GNT0, GNT1. The state register is updated on the rising edge of clk.
- rst low forces IDLE immediately (asynchronous). All outputs are then 0, including s_cyc_o/s_stb_o, both acks and both data_o.
- Output muxing (combinational from the state):
  - IDLE: all s_* outputs are 0; s_ack_i is ignored; m0/m1 ack_o and data_o are 0.
  - GNTn: s_addr/data/we/sel_o equal mn_*; s_cyc_o = mn_cyc_i; s_stb_o = mn_cyc_i & mn_stb_i.
  - GNTn: mn_ack_o = s_ack_i & s_stb_o; mn_data_o = s_data_i when mn_ack_o=1, else 0. The non-granted master sees ack=0 and data=0.
- Transitions:
  - IDLE: m0_cyc_i=1 -> GNT0; else m1_cyc_i=1 -> GNT1; else stay. Master 0 wins a simultaneous request from IDLE.
  - GNT0: stay while m0_cyc_i=1. When m0_cyc_i=0: m1_cyc_i=1 -> GNT1, else IDLE.
  - GNT1: stay while m1_cyc_i=1. When m1_cyc_i=0: m0_cyc_i=1 -> GNT0, else IDLE.
  - Back-to-back contention therefore alternates, so neither master starves.
- Latency:
  - From IDLE, one cycle of grant latency: a request seen at edge k is forwarded to the slave from cycle k+1.
  - Direct handoff GNT0<->GNT1 adds no idle cycle beyond the master's own cyc deassertion cycle.
  - Ack and read data pass through combinationally, with zero added latency.
- Grant never changes while the granted master holds cyc=1, even if the other master asserts cyc.
- A master that drops cyc without having received ack abandons the cycle (e.g. pipeline flush). s_cyc_o drops in the same cycle, and a slave ack arriving afterwards is not forwarded.
- Reset asserted mid-cycle: s_cyc_o/s_stb_o drop asynchronously, and no ack is delivered to either master.
- arb_timeout_o is 0 at all times without the optional feature.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 10-bit counter clears on reset, on any state change, and on s_ack_i=1.
  - It increments each cycle the state is GNTn with s_stb_o=1 and s_ack_i=0.
  - When the counter equals TIMEOUT_CYCLES, the arbiter asserts mn_ack_o=1 with mn_data_o=32'h0 and arb_timeout_o=1 for exactly that one cycle, regardless of s_ack_i.
  - The counter then clears, and the grant is kept until the master drops cyc.
  - This prevents a dead slave from stalling the CPU forever.
- Without the macro: no counter is generated, and arb_timeout_o is tied to 0.

Test Plan:
- Reset: rst=0 with both cyc=1 -> s_cyc_o=0, m0_ack_o=m1_ack_o=0, state IDLE; release rst -> GNT0 at the next edge.
- Single master 1 read, addr 32'h0000_0100, slave acks 2 cycles after the grant with s_data_i=32'hCAFE_F00D -> m1_ack_o=1 and m1_data_o=32'hCAFE_F00D in the same cycle; m0_ack_o=0 throughout.
- Simultaneous request from IDLE (m0 write 32'h1234_5678 with sel 4'b0011, m1 read) -> m0 served first with s_sel_o=4'b0011; after m0 drops cyc, GNT1 follows immediately with no IDLE cycle.
- Flush abandon: m0 granted, m0_cyc_i drops before ack, slave acks one cycle later -> s_cyc_o=0 in the drop cycle and m0_ack_o stays 0.
- Hold: m1 granted, m0 asserts cyc mid-cycle -> s_addr_o stays m1_addr_i until m1 is acked and drops cyc, then GNT0.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4, slave never acks -> m0_ack_o=1, m0_data_o=0 and arb_timeout_o=1 on the 5th stalled cycle only; without the macro, no ack ever arrives and arb_timeout_o stays 0.
